// File: rtl/fb_pkg.sv
// Frame-buffer constants shared by the writer and the VGA reader.
// The buffer holds 320x240 pixels of 12-bit 4:4:4 RGB, shown at 640x480 with 2x replication.
package fb_pkg;

  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_PIX_W  = 12;
  localparam int unsigned FB_WORDS  = FB_W * FB_H;
  localparam int unsigned VGA_ACT_W = 2 * FB_W;
  localparam int unsigned VGA_ACT_H = 2 * FB_H;

  // Timing side-band bundle that travels down the pipeline beside the pixel data.
  typedef struct packed {
    logic first;   // hcount == 0 && vcount == 0
    logic blank;
    logic vsync;
    logic hsync;
  } vga_ctl_t;

  // Syncs idle high and the screen is blanked while the pipeline is empty.
  localparam vga_ctl_t VGA_CTL_IDLE = '{first: 1'b0, blank: 1'b1, vsync: 1'b1, hsync: 1'b1};

endpackage

// File: rtl/fb_vga_reader_if.sv
// BRAM port B as seen by the frame-buffer reader: address and write enable out, data back.
interface fb_vga_reader_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 12
) ();

  logic [ADDR_W-1:0] b_addr;
  logic              b_wr;
  logic [PIX_W-1:0]  b_dout;

  modport master (output b_addr, output b_wr, input b_dout);
  modport slave  (input b_addr, input b_wr, output b_dout);

endinterface

// File: rtl/fb_delay_line.sv
// Fixed-depth shift register that keeps the timing side-band aligned with the BRAM read.
module fb_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: every stage is reset, not just the head: the tail drives outputs directly,
  // so a stale stage would leak a bogus sync edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_vga_reader.sv
// Read side of the frame buffer: display counters -> BRAM address -> RGB, with the
// syncs and blank delayed so they leave the block in step with the pixel they belong to.
module fb_vga_reader
  import fb_pkg::*;
#(
  parameter int unsigned      SRC_W     = FB_W,
  parameter int unsigned      SRC_H     = FB_H,
  parameter int unsigned      ADDR_W    = FB_ADDR_W,
  parameter int unsigned      PIX_W     = FB_PIX_W,
  parameter int unsigned      RD_LAT    = 1,
  parameter logic [PIX_W-1:0] BLANK_PIX = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             blank_in,
  fb_vga_reader_if.master  bram,
  output logic [PIX_W-1:0] pixel,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             blank_out,
  output logic             frame_start
);

  localparam int unsigned       LAT      = 2 + RD_LAT;
  localparam logic [10:0]       H_END    = 11'(2 * SRC_W);
  localparam logic [9:0]        V_END    = 10'(2 * SRC_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'((SRC_H - 1) * SRC_W);

  logic              act;
  logic              line_end;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] row_base_next;
  logic [ADDR_W-1:0] addr_next;
  vga_ctl_t          ctl_in;
  vga_ctl_t          ctl_tap;

  assign bram.b_wr = 1'b0;

  // NOTE: every signal written here gets a value before any branch, so no latch can form.
  always_comb begin
    act           = (hcount < H_END) && (vcount < V_END);
    line_end      = (hcount == H_END - 11'd1);
    addr_next     = row_base + ADDR_W'(hcount[10:1]);
    row_base_next = row_base;
    if (vcount >= V_END) begin
      row_base_next = '0;
    end else if (line_end && vcount[0] && (vcount != V_END - 10'd1) && (row_base < ROW_LAST)) begin
      // Odd lines advance the base; even lines reuse it, which doubles every source row.
      row_base_next = row_base + ROW_STEP;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_base    <= '0;
      bram.b_addr <= '0;
    end else begin
      row_base <= row_base_next;
      if (act) bram.b_addr <= addr_next;
    end
  end

  always_comb begin
    ctl_in       = VGA_CTL_IDLE;
    ctl_in.first = (hcount == 11'd0) && (vcount == 10'd0);
    ctl_in.blank = blank_in;
    ctl_in.vsync = vsync_in;
    ctl_in.hsync = hsync_in;
  end

  // Address register plus the BRAM read; the output register below is the last stage.
  fb_delay_line #(
    .WIDTH    ($bits(vga_ctl_t)),
    .DEPTH    (LAT - 1),
    .RESET_VAL(VGA_CTL_IDLE)
  ) u_ctl_dly (
    .clk  (clk),
    .reset(reset),
    .d    (ctl_in),
    .q    (ctl_tap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel       <= BLANK_PIX;
      hsync_out   <= VGA_CTL_IDLE.hsync;
      vsync_out   <= VGA_CTL_IDLE.vsync;
      blank_out   <= VGA_CTL_IDLE.blank;
      frame_start <= VGA_CTL_IDLE.first;
    end else begin
      pixel       <= ctl_tap.blank ? BLANK_PIX : bram.b_dout;
      hsync_out   <= ctl_tap.hsync;
      vsync_out   <= ctl_tap.vsync;
      blank_out   <= ctl_tap.blank;
      frame_start <= ctl_tap.first;
    end
  end

endmodule

// File: tb/tb_fb_vga_reader.sv
// Self-checking bench for fb_vga_reader: BRAM model, abstract pixel/address model, frame sweeps.
module tb_fb_vga_reader;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in, vsync_in, blank_in;
  logic [11:0] pixel;
  logic        hsync_out, vsync_out, blank_out, frame_start;

  fb_vga_reader_if #(.ADDR_W(FB_ADDR_W), .PIX_W(FB_PIX_W)) bram_if ();

  fb_vga_reader dut (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .bram       (bram_if.master),
    .pixel      (pixel),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // One-clock-latency BRAM read port.
  logic [11:0] mem [FB_WORDS];
  always @(posedge clk)
    bram_if.b_dout <= (bram_if.b_addr < FB_WORDS) ? mem[bram_if.b_addr] : 12'hBAD;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
    int addr;
    bit valid;
  } rec_t;

  typedef struct {
    int h;
    int v;
    bit bl;
    int exp_addr;
    int exp_pix;
  } vec_t;

  rec_t hist[$];
  int   model_addr;
  bit   model_ok;
  int   n_cmp;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_le(input string name, input logic [31:0] act, input logic [31:0] lim);
    n_cmp++;
    if (!(act <= lim)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at most %0d (t=%0t)", name, act, lim, $time);
    end
  endtask

  // Apply one set of timing inputs, advance a clock, and check everything the model knows.
  task automatic cycle(input int h, input int v, input bit hs, input bit vs, input bit bl);
    rec_t r;
    hcount   = 11'(h);
    vcount   = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    blank_in = bl;
    if (h == 0 && v == 0) model_ok = 1'b1;
    if (h < VGA_ACT_W && v < VGA_ACT_H) model_addr = (v / 2) * FB_W + h / 2;
    r = '{h: h, v: v, hs: hs, vs: vs, bl: bl, addr: model_addr, valid: model_ok};
    hist.push_front(r);
    @(posedge clk);
    #1;
    check_le("addr_range", bram_if.b_addr, FB_WORDS - 1);
    if (hist[0].valid) check("b_addr", bram_if.b_addr, hist[0].addr);
    if (hist.size() >= 3) begin
      r = hist[2];
      check("hsync_out", hsync_out, r.hs);
      check("vsync_out", vsync_out, r.vs);
      check("blank_out", blank_out, r.bl);
      check("frame_start", frame_start, (r.h == 0 && r.v == 0));
      if (r.valid) check("pixel", pixel, r.bl ? 12'h000 : mem[r.addr]);
    end
    while (hist.size() > 3) void'(hist.pop_back());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel"}, pixel, 12'h000);
    check({tag, "_hsync"}, hsync_out, 1'b1);
    check({tag, "_vsync"}, vsync_out, 1'b1);
    check({tag, "_blank"}, blank_out, 1'b1);
    check({tag, "_fstart"}, frame_start, 1'b0);
    check({tag, "_b_addr"}, bram_if.b_addr, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_reset_outputs("mid_rst");
    end
    reset = 1'b0;
    hist.delete();
    model_ok = 1'b0;
  endtask

  // One 800x525 frame with a randomly thinned hcount walk; 639 is always visited.
  task automatic run_frame(input int rst_v);
    int fs_cnt;
    int h;
    int nh;
    bit bl;
    fs_cnt = 0;
    for (int v = 0; v < 525; v++) begin
      h = 0;
      while (h < 800) begin
        if (v == rst_v && h == 0) do_reset(2);
        if (h < VGA_ACT_W && v < VGA_ACT_H)
          bl = (h == 0 && v == 0) ? 1'b0 : ($urandom_range(0, 15) == 0);
        else
          bl = 1'b1;
        cycle(h, v, !(h >= 656 && h < 752), !(v >= 490 && v < 492), bl);
        if (frame_start) begin
          fs_cnt++;
          check("fs_pixel", pixel, mem[0]);
        end
        if (model_ok) begin
          if (h == 0 && (v == 0 || v == 1)) check("row0_addr", bram_if.b_addr, 0);
          if (h == 0 && v == 2) check("row1_addr", bram_if.b_addr, 320);
          if (h == 639 && v == 479) check("last_addr", bram_if.b_addr, 76799);
        end
        nh = h + int'($urandom_range(1, 80));
        if (h < 639 && nh > 639) nh = 639;
        h = nh;
      end
    end
    check("fs_count", fs_cnt, 1);
  endtask

  vec_t vec[10];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    model_addr = 0;
    model_ok   = 1'b1;
    for (int i = 0; i < int'(FB_WORDS); i++) mem[i] = 12'(i);

    // Reset with no timing activity.
    reset    = 1'b1;
    hcount   = '0;
    vcount   = '0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    blank_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Pixel replication on the first row: addresses and pixels pair up.
    for (int i = 0; i < 8; i++) vec[i] = '{h: i, v: 0, bl: 1'b0, exp_addr: i / 2, exp_pix: i / 2};
    vec[8] = '{h: 640, v: 0, bl: 1'b1, exp_addr: 3, exp_pix: 0};
    vec[9] = '{h: 640, v: 0, bl: 1'b1, exp_addr: 3, exp_pix: 0};
    for (int i = 0; i < 10; i++) begin
      cycle(vec[i].h, vec[i].v, 1'b1, 1'b1, vec[i].bl);
      check("ramp_addr", bram_if.b_addr, vec[i].exp_addr);
      if (i >= 2) check("ramp_pixel", pixel, vec[i-2].exp_pix);
    end

    // Blank masks a bright BRAM word exactly where the delayed blank is high.
    for (int i = 0; i < 32; i++) mem[i] = 12'hFFF;
    hist.delete();
    for (int h = 0; h < 24; h++)
      cycle(h, 0, h[2], h[3], (h >= 5 && h < 11) || h == 17);
    for (int i = 0; i < 3; i++) cycle(640, 0, 1'b0, 1'b1, 1'b1);

    // Full frames over random image content, including a mid-frame reset.
    for (int i = 0; i < int'(FB_WORDS); i++) mem[i] = 12'($urandom);
    hist.delete();
    run_frame(-1);
    run_frame(-1);
    run_frame(200);
    run_frame(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
